fact_accel: RTL and testbench
=============================

# fact_accel

Memory-mapped iterative factorial accelerator, the peripheral on the SoC side of the processor bus. The SoC address decoder qualifies the processor store strobe and routes word-address bits to this block. The block returns read data to the SoC read mux and drives the `faccel_done` level into the processor. It computes n! for 4-bit n, using one 32-bit multiply per clock, and flags an error for results that overflow 32 bits.

## Interface
Parameters:
- `NMAX`, default 12: largest n whose factorial fits in 32 bits; n > NMAX is an error.

Ports:
- `clk` input, 1: system clock; all state changes on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `we` input, 1: write strobe, already qualified by the SoC decoder for this block's address window.
- `a` input, 2: register select, driven from processor byte address bits [3:2].
- `wd` input, 32: write data.
- `rd` output, 32: read data, combinational from `a`.
- `done` output, 1: copy of the status done bit; connects to `faccel_done`.

## Operation
Register map (`a`):
- 0 N: R/W. A write stores `wd[3:0]`. Reads return `{28'b0, n}`.
- 1 CTRL: W; R returns `{31'b0, busy}`. A write with `wd[0]`=1 is a start command. A write with `wd[0]`=0 has no effect.
- 2 STATUS: R only. Reads return `{30'b0, err, done}`. Writes are ignored.
- 3 RESULT: R only, 32 bits. Writes are ignored.

State machine IDLE → BUSY → DONE:
- IDLE/DONE + start with n > NMAX: go to DONE. Set `err`=1, `done`=1, result=0, all on the start edge.
- IDLE/DONE + start with n ≤ NMAX: go to BUSY. Load `cnt`←n, `prod`←1, and clear `done` and `err`.
- BUSY, `cnt` ≤ 1: go to DONE. Set result←`prod` and `done`=1.
- BUSY, `cnt` > 1: `prod`←`prod`×`cnt` (low 32 bits; no overflow is possible when n ≤ NMAX), then `cnt`←`cnt`−1.
- A start while BUSY is ignored. The current job continues unchanged.
- A write to N while BUSY updates the N register only. The running job uses its latched `cnt`.
- DONE holds `done`, `err` and result until the next start or reset. A new start from DONE is legal.
- `busy` = (state == BUSY).

Reset, at any time including mid-computation:
- State returns to IDLE.
- n, `cnt`, `prod`, result, `done` and `err` are all cleared to 0.
- `rd` immediately reflects the zeroed registers.

## Timing
- Writes take effect on the rising edge where `we`=1.
- Reads are combinational: `rd` reflects register state in the same cycle `a` changes. This matches the single-cycle processor load path.
- Call the start edge k. For valid n, `done` rises after edge k+max(n,1) and `busy` is high from edge k to that edge. Examples: n=0 or 1 gives done after k+1; n=5 gives k+5; n=12 gives k+12.
- Error case: `done` and `err` are high right after edge k. `busy` never asserts.
- `done` falls on the start edge of the next job.
- `rd` has no registered latency; `done` is a registered level with no glitches.

## Test plan
- Reset, then read all four registers → 0, 0, 0, 0. `done`=0.
- Write N=5, write CTRL=1, poll STATUS → busy for 5 cycles, then STATUS=1 and RESULT=120 (0x78).
- N=12 → RESULT=479001600 (0x1C8CFC00) after 12 cycles. N=0 → RESULT=1 after 1 cycle, `err`=0.
- N=13, start → on the next cycle STATUS=3 (err+done), RESULT=0, CTRL read = 0.
- Start N=6 mid-job:
  - Write N=3 and CTRL=1 while busy → final RESULT=720, and the busy interval is unchanged.
  - A subsequent start → RESULT=6.
- Assert `reset` for one cycle during the 3rd busy cycle of an N=10 job → all reads 0, `done`=0. A fresh start with N=4 then yields RESULT=24.

Source files
------------

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator: computes n! for a 4-bit n,
// one 32-bit multiply per clock, flagging n > NMAX as an overflow error.
module fact_accel #(
    parameter int unsigned NMAX = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;
    localparam logic [3:0] NMAX_L   = 4'(NMAX);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_n;
    logic [3:0]  r_cnt;
    logic [31:0] r_prod;
    logic [31:0] r_result;
    logic        r_done;
    logic        r_err;

    logic        w_start;
    logic        w_n_bad;
    logic        w_cnt_last;
    logic        w_busy;
    logic        w_load_ok;
    logic        w_load_err;
    logic        w_step;
    logic        w_finish;
    logic        w_unused_wd;

    assign w_start     = we && (a == A_CTRL) && wd[0];
    assign w_n_bad     = r_n > NMAX_L;
    assign w_cnt_last  = r_cnt <= 4'd1;
    assign w_unused_wd = &{1'b0, wd[31:4]};

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_next = w_n_bad ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_cnt_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state == S_BUSY);
        w_load_ok  = 1'b0;
        w_load_err = 1'b0;
        w_step     = 1'b0;
        w_finish   = 1'b0;
        if (w_busy) begin
            w_finish = w_cnt_last;
            w_step   = !w_cnt_last;
        end else if (w_start) begin
            w_load_err = w_n_bad;
            w_load_ok  = !w_n_bad;
        end
    end

    // A write to N while busy only changes r_n; the job runs from r_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n      <= 4'd0;
            r_cnt    <= 4'd0;
            r_prod   <= 32'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (we && (a == A_N)) begin
                r_n <= wd[3:0];
            end
            if (w_load_err) begin
                r_done   <= 1'b1;
                r_err    <= 1'b1;
                r_result <= 32'd0;
            end else if (w_load_ok) begin
                r_cnt  <= r_n;
                r_prod <= 32'd1;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else if (w_finish) begin
                r_result <= r_prod;
                r_done   <= 1'b1;
            end else if (w_step) begin
                r_prod <= r_prod * {28'd0, r_cnt};
                r_cnt  <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        rd = 32'd0;
        case (a)
            A_N:      rd = {28'd0, r_n};
            A_CTRL:   rd = {31'd0, w_busy};
            A_STATUS: rd = {30'd0, r_err, r_done};
            A_RESULT: rd = r_result;
            default:  rd = 32'd0;
        endcase
    end

    assign done = r_done;

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: a job-level reference model compared
// every cycle, plus directed jobs with hand-computed results and latencies.
module tb_fact_accel;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    fact_accel #(.NMAX(12)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Job-level model: a valid job finishes max(n,1) edges after its start.
    logic [3:0]  m_n;
    int          m_left;
    logic [31:0] m_pend;
    logic [31:0] m_result;
    logic        m_done;
    logic        m_err;

    function automatic logic [31:0] fact(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 2; i <= n; i++) p = p * 64'(i);
        return p[31:0];
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] sel);
        case (sel)
            2'd0:    return {28'd0, m_n};
            2'd1:    return {31'd0, (m_left > 0)};
            2'd2:    return {30'd0, m_err, m_done};
            default: return m_result;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_n = 4'd0; m_left = 0; m_pend = 32'd0;
            m_result = 32'd0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done   = 1'b1;
                    m_result = m_pend;
                end
            end else if (we && a == 2'd1 && wd[0]) begin
                if (m_n > 4'd12) begin
                    m_done = 1'b1; m_err = 1'b1; m_result = 32'd0;
                end else begin
                    m_left = (m_n == 4'd0) ? 1 : int'(m_n);
                    m_pend = fact(int'(m_n));
                    m_done = 1'b0; m_err = 1'b0;
                end
            end
            if (we && a == 2'd0) m_n = wd[3:0];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_vs_model", rd, model_rd(a));
            check("done_vs_model", {31'd0, done}, {31'd0, m_done});
        end
    end

    // Returns 2 ns after the write edge.
    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        @(posedge clk); #2;
        we = 1'b1; a = sel; wd = d;
        @(posedge clk); #2;
        we = 1'b0; wd = 32'd0;
    endtask

    task automatic rdchk(input logic [1:0] sel, input logic [31:0] exp, input string nm);
        @(posedge clk); #2;
        a = sel;
        #1 check(nm, rd, exp);
    endtask

    // Counts edges until STATUS.done, bounded so a stuck DUT still terminates.
    task automatic poll(output int cyc);
        a = 2'd2;
        #1;
        cyc = 0;
        while (rd[0] !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_job(input logic [3:0] n, input int lat, input logic [31:0] res, input string nm);
        int cyc;
        wr(2'd0, {28'd0, n});
        wr(2'd1, 32'd1);
        poll(cyc);
        check({nm, "_latency"}, cyc, lat);
        rdchk(2'd2, 32'd1, {nm, "_status"});
        rdchk(2'd3, res, {nm, "_result"});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1; we = 1'b0; a = 2'd0; wd = 32'd0;
        repeat (3) @(posedge clk);
        #2 chk_en = 1'b1;
        reset = 1'b0;

        rdchk(2'd0, 32'd0, "reset_n");
        rdchk(2'd1, 32'd0, "reset_ctrl");
        rdchk(2'd2, 32'd0, "reset_status");
        rdchk(2'd3, 32'd0, "reset_result");
        check("reset_done", {31'd0, done}, 32'd0);

        run_job(4'd0, 1, 32'd1, "n0");
        run_job(4'd5, 5, 32'd120, "n5");
        rdchk(2'd0, 32'd5, "n_readback");
        run_job(4'd12, 12, 32'h1C8C_FC00, "n12");
        run_job(4'd1, 1, 32'd1, "n1");

        // Non-start CTRL writes and writes to read-only registers change nothing.
        wr(2'd1, 32'hFFFF_FFFE);
        rdchk(2'd1, 32'd0, "ctrl_nostart_busy");
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hDEAD_BEEF);
        rdchk(2'd2, 32'd1, "ro_status");
        rdchk(2'd3, 32'd1, "ro_result");

        // Overflow error: done and err right after the start edge.
        wr(2'd0, 32'd13);
        wr(2'd1, 32'd1);
        a = 2'd2;
        #1 check("n13_status_now", rd, 32'd3);
        rdchk(2'd2, 32'd3, "n13_status");
        rdchk(2'd3, 32'd0, "n13_result");
        rdchk(2'd1, 32'd0, "n13_busy");

        // N write and restart during a job must not disturb it.
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        poll(cyc);
        check("midjob_latency", 32'(cyc + 4), 32'd6);
        rdchk(2'd3, 32'd720, "midjob_result");
        rdchk(2'd0, 32'd3, "midjob_n");
        wr(2'd1, 32'd1);
        poll(cyc);
        check("restart_latency", cyc, 32'd3);
        rdchk(2'd3, 32'd6, "restart_result");

        // Reset during the third busy cycle of an N=10 job.
        wr(2'd0, 32'd10);
        wr(2'd1, 32'd1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        rdchk(2'd0, 32'd0, "rst_mid_n");
        rdchk(2'd1, 32'd0, "rst_mid_ctrl");
        rdchk(2'd2, 32'd0, "rst_mid_status");
        rdchk(2'd3, 32'd0, "rst_mid_result");
        check("rst_mid_done", {31'd0, done}, 32'd0);
        run_job(4'd4, 4, 32'd24, "post_rst_n4");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
